// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls from later stages, the
// instruction-memory address/data pair, and the IF/ID register outputs.
// The fetch stage is the slave; the surrounding pipeline is the master.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        addr_err;
  logic [31:0] fetch_count;

  modport master (
    output stall, flush, redirect_valid, redirect_pc, inst,
    input  inst_addr, if_id_inst, if_id_pc, if_id_pc_plus4, if_id_valid,
           addr_err, fetch_count
  );

  modport slave (
    input  stall, flush, redirect_valid, redirect_pc, inst,
    output inst_addr, if_id_inst, if_id_pc, if_id_pc_plus4, if_id_valid,
           addr_err, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the zero-latency
// instruction memory and fills the IF/ID pipeline register.
// Per-edge priority: redirect > stall > flush > normal fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  if_stage_if.slave bus
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] inst_q,     inst_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic        valid_q,    valid_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection; a stall drops any concurrent flush because
  // decode re-presents it once the stall clears.
  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    valid_d    = valid_q;
    addr_err_d = 1'b0;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_pc[31:2], 2'b00};
      inst_d     = 32'h0;
      id_pc_d    = 32'h0;
      id_pc4_d   = 32'h0;
      valid_d    = 1'b0;
      addr_err_d = (bus.redirect_pc[1:0] != 2'b00);
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.flush) begin
      pc_d     = pc_plus4;
      inst_d   = 32'h0;
      id_pc_d  = 32'h0;
      id_pc4_d = 32'h0;
      valid_d  = 1'b0;
    end else begin
      pc_d     = pc_plus4;
      inst_d   = bus.inst;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      count_d  = count_q + 32'd1;
    end
  end

  // State registers with asynchronous reset overriding everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      id_pc_q    <= 32'h0;
      id_pc4_q   <= 32'h0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
      count_q    <= count_d;
    end
  end

  assign bus.inst_addr      = pc_q;
  assign bus.if_id_inst     = inst_q;
  assign bus.if_id_pc       = id_pc_q;
  assign bus.if_id_pc_plus4 = id_pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.addr_err       = addr_err_q;
  assign bus.fetch_count    = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an expected-state scoreboard.
module tb_if_stage;

  logic clk;
  logic rst;
  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign bus.inst = mem[bus.inst_addr[7:2]];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_cnt;
  logic        m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
  endtask

  // Drive one cycle of controls, predict the post-edge state, then compare.
  task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    exp_t e;
    bus.stall = st; bus.flush = fl; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    m_err = 1'b0;
    if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
      m_err = (rpc[1:0] != 2'b00);
    end else if (st) begin
      // hold
    end else if (fl) begin
      m_pc = m_pc + 32'd4;
      m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_inst = mem[m_pc[7:2]];
      m_ipc = m_pc;
      m_ipc4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    e.addr = m_pc; e.inst = m_inst; e.ipc = m_ipc; e.ipc4 = m_ipc4;
    e.valid = m_valid; e.err = m_err; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_err++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("inst_addr",      bus.inst_addr,            e.addr);
      chk("if_id_inst",     bus.if_id_inst,           e.inst);
      chk("if_id_pc",       bus.if_id_pc,             e.ipc);
      chk("if_id_pc_plus4", bus.if_id_pc_plus4,       e.ipc4);
      chk("if_id_valid",    {31'h0, bus.if_id_valid}, {31'h0, e.valid});
      chk("addr_err",       {31'h0, bus.addr_err},    {31'h0, e.err});
      chk("fetch_count",    bus.fetch_count,          e.cnt);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  bus.inst_addr,            32'h0);
    chk({tag, "_inst"},  bus.if_id_inst,           32'h0);
    chk({tag, "_pc"},    bus.if_id_pc,             32'h0);
    chk({tag, "_pc4"},   bus.if_id_pc_plus4,       32'h0);
    chk({tag, "_valid"}, {31'h0, bus.if_id_valid}, 32'h0);
    chk({tag, "_err"},   {31'h0, bus.addr_err},    32'h0);
    chk({tag, "_cnt"},   bus.fetch_count,          32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0]  = 32'h0800_0004;
    mem[4]  = 32'h8C01_0004;
    mem[63] = 32'h2402_0063;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    model_reset();

    // Reset for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    // First fetch captures Mem[RESET_PC] with no dead cycle
    step(0, 0, 0, 32'h0);
    chk("boot_inst", bus.if_id_inst, 32'h0800_0004);
    chk("boot_addr", bus.inst_addr, 32'h4);

    // Jump to 0x10, then the lw there
    step(0, 0, 1, 32'h10);
    chk("jmp_cnt", bus.fetch_count, 32'h1);
    step(0, 0, 0, 32'h0);
    chk("lw_inst", bus.if_id_inst, 32'h8C01_0004);
    chk("lw_pc",   bus.if_id_pc,   32'h10);

    // Three stalled cycles at 0x14, then release
    repeat (3) step(1, 0, 0, 32'h0);
    chk("stall_addr", bus.inst_addr, 32'h14);
    step(0, 0, 0, 32'h0);
    chk("unstall_pc", bus.if_id_pc, 32'h14);

    // Redirect beats stall, stall beats flush, then flush alone
    step(1, 0, 1, 32'h2C);
    chk("rs_addr", bus.inst_addr, 32'h2C);
    step(1, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    chk("fl_addr", bus.inst_addr, 32'h30);
    step(0, 0, 0, 32'h0);

    // Misaligned redirect: aligned PC and a single-cycle error pulse
    step(0, 0, 1, 32'h13);
    chk("mis_addr", bus.inst_addr, 32'h10);
    chk("mis_err",  {31'h0, bus.addr_err}, 32'h1);
    step(0, 0, 0, 32'h0);

    // Wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    chk("wrap_addr", bus.inst_addr, 32'h0);
    chk("wrap_pc4",  bus.if_id_pc_plus4, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h3);
    step(0, 0, 0, 32'h0);

    // Async reset between edges during a stall
    bus.stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 32'h0);
    chk("rearm_inst", bus.if_id_inst, 32'h0800_0004);

    chk("sb_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Handles stall, flush and PC redirect (branch/jump) requests from later stages, and keeps a fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall from decode; holds PC and IF/ID.
- flush  input  1  kills the instruction being captured this cycle (bubble into IF/ID).
- redirect_valid  input  1  taken branch or jump this cycle.
- redirect_pc  input  32  redirect target byte address.
- inst_addr  output  32  byte address to instruction memory; equals pc.
- inst  input  32  instruction word returned combinationally for inst_addr.
- if_id_inst  output  32  registered instruction to decode.
- if_id_pc  output  32  registered address of if_id_inst.
- if_id_pc_plus4  output  32  registered if_id_pc+4, used for branch and jump target math.
- if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- addr_err  output  1  registered one-cycle pulse: accepted redirect had redirect_pc[1:0]!=0.
- fetch_count  output  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset is asynchronous and active-high; it overrides everything, including mid-stall and mid-redirect. Reset values:
  - pc = RESET_PC
  - if_id_inst = 0, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_valid = 0
  - addr_err = 0, fetch_count = 0
- inst_addr = pc, combinational from the PC register. Memory latency is zero: inst is valid in the same cycle.
- Per-edge priority, highest first: redirect_valid > stall > flush > normal.
- Redirect (redirect_valid=1, regardless of stall/flush):
  - pc <= {redirect_pc[31:2], 2'b00}
  - IF/ID <= bubble: inst=32'h0 (nop), pc and pc_plus4 = 0, valid=0
  - addr_err <= (redirect_pc[1:0] != 0)
  - fetch_count unchanged
- Stall (stall=1, no redirect):
  - pc holds and all IF/ID fields hold, even if flush=1; the flush is dropped.
  - Decode re-presents flush once stall is released.
- Flush (flush=1, no stall, no redirect):
  - pc <= pc+4
  - IF/ID <= bubble; fetch_count unchanged.
- Normal:
  - pc <= pc+4
  - if_id_inst <= inst, if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_valid <= 1
  - fetch_count <= fetch_count+1
- addr_err is 0 on every edge except an accepted misaligned redirect.
- Arithmetic:
  - pc+4 is 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000 with no flag.
  - fetch_count wraps at 2^32.
- First fetch after reset deasserts: on the first rising edge, if_id captures Mem at RESET_PC. No extra dead cycle.
- A bubble is a true nop (all-zero word), so decode can also ignore if_id_valid safely.
- No combinational path from any input to any registered output. inst_addr depends only on the pc register.

Test Plan:
- Reset and sequential fetch: rst high 2 cycles, release, memory loaded with the team boot program (Mem[0]=32'h08000004). After edge 1: if_id_inst=32'h08000004, if_id_pc=0, if_id_pc_plus4=4, if_id_valid=1, inst_addr=4, fetch_count=1.
- Jump redirect: at pc=4, redirect_valid=1, redirect_pc=32'h10. Next edge: inst_addr=32'h10, if_id_valid=0, if_id_inst=0, fetch_count unchanged. Following edge: if_id_inst=32'h8C010004 (lw), if_id_pc=32'h10.
- Stall: at pc=32'h14, stall=1 for 3 cycles. PC and IF/ID are unchanged for all 3. On release, the next edge captures the pc=32'h14 instruction.
- Redirect beats stall, stall beats flush:
  - stall=1 with redirect_valid=1, redirect_pc=32'h2C: pc becomes 32'h2C and IF/ID goes to bubble.
  - stall=1 with flush=1: everything holds.
  - flush alone: IF/ID goes to bubble and pc advances by 4.
- Misaligned redirect and wrap:
  - redirect_pc=32'h13: pc=32'h10 and a single-cycle addr_err pulse.
  - Force redirect_pc=32'hFFFFFFFC, then run normal: pc wraps to 0, and if_id_pc_plus4=0 for that instruction.
- Async reset mid-operation: assert rst between clock edges during a stall. All outputs go to reset values immediately, without waiting for clk.
